// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bus for the async FIFO write controller. It groups the write
// request, the Gray read pointer crossing from the read domain and the
// status/strobe outputs returned to the writer.
interface fifo_wr_ctrl_if #(
    parameter int ADDR_WIDTH = 5
);
    logic                  i_w_inc;
    logic [ADDR_WIDTH:0]   i_r_ptr_gray;
    logic [ADDR_WIDTH:0]   i_afull_thresh;
    logic                  i_ovf_clr;
    logic                  o_wr_en;
    logic [ADDR_WIDTH-1:0] o_wr_addr;
    logic [ADDR_WIDTH:0]   o_w_ptr_gray;
    logic                  o_w_full;
    logic                  o_w_afull;
    logic [ADDR_WIDTH:0]   o_w_level;
    logic                  o_ovf;

    modport master (
        output i_w_inc, i_r_ptr_gray, i_afull_thresh, i_ovf_clr,
        input  o_wr_en, o_wr_addr, o_w_ptr_gray, o_w_full, o_w_afull,
               o_w_level, o_ovf
    );

    modport slave (
        input  i_w_inc, i_r_ptr_gray, i_afull_thresh, i_ovf_clr,
        output o_wr_en, o_wr_addr, o_w_ptr_gray, o_w_full, o_w_afull,
               o_w_level, o_ovf
    );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of an asynchronous FIFO: binary/Gray write
// pointer, read-pointer synchronizer, full/almost-full/level status and a
// sticky overflow flag for writes attempted while full.
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH  = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic           i_w_clk,
    input  logic           i_rst_n,
    fifo_wr_ctrl_if.slave  bus
);
    localparam int PW = ADDR_WIDTH + 1;

    // Binary to reflected Gray code.
    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    // Reflected Gray code back to binary (prefix XOR from the MSB down).
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wbin_r;
    logic [PW-1:0] wgray_r;
    logic [PW-1:0] rq_sync_r [SYNC_STAGES];
    logic          ovf_r;

    logic [PW-1:0] wbin_nxt_s;
    logic [PW-1:0] wgray_nxt_s;
    logic          ovf_nxt_s;
    logic [PW-1:0] rq_s;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] level_s;
    logic          full_s;
    logic          afull_s;
    logic          wr_en_s;

    // Status derived from registers only: last sync stage vs. Gray write pointer.
    always_comb begin
        rq_s    = rq_sync_r[SYNC_STAGES-1];
        rbin_s  = gray2bin(rq_s);
        level_s = wbin_r - rbin_s;
        full_s  = (wgray_r == {~rq_s[PW-1:PW-2], rq_s[PW-3:0]});
        afull_s = (level_s >= bus.i_afull_thresh);
        // The strobe is gated by reset so nothing is written while it is held.
        wr_en_s = bus.i_w_inc & ~full_s & i_rst_n;
    end

    // Next pointer values and sticky overflow update (set beats clear).
    always_comb begin
        wbin_nxt_s  = wbin_r;
        wgray_nxt_s = wgray_r;
        ovf_nxt_s   = ovf_r;
        if (wr_en_s) begin
            wbin_nxt_s  = wbin_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
            wgray_nxt_s = bin2gray(wbin_r + {{ADDR_WIDTH{1'b0}}, 1'b1});
        end else begin
            wbin_nxt_s  = wbin_r;
            wgray_nxt_s = wgray_r;
        end
        if (bus.i_w_inc && full_s) begin
            ovf_nxt_s = 1'b1;
        end else if (bus.i_ovf_clr) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // Write pointers (binary and Gray move on the same edge) and overflow flag.
    always_ff @(posedge i_w_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wbin_r  <= {PW{1'b0}};
            wgray_r <= {PW{1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            wbin_r  <= wbin_nxt_s;
            wgray_r <= wgray_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    // Plain flop chain bringing the Gray read pointer into the write domain.
    always_ff @(posedge i_w_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rq_sync_r[i] <= {PW{1'b0}};
            end
        end else begin
            rq_sync_r[0] <= bus.i_r_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rq_sync_r[i] <= rq_sync_r[i-1];
            end
        end
    end

    assign bus.o_wr_en      = wr_en_s;
    assign bus.o_wr_addr    = wbin_r[ADDR_WIDTH-1:0];
    assign bus.o_w_ptr_gray = wgray_r;
    assign bus.o_w_full     = full_s;
    assign bus.o_w_afull    = afull_s;
    assign bus.o_w_level    = level_s;
    assign bus.o_ovf        = ovf_r;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed self-checking bench for fifo_wr_ctrl (ADDR_WIDTH=4, SYNC_STAGES=2):
// reset, fill, overflow, drain latency, almost-full and pointer wrap.
module tb_fifo_wr_ctrl;
    logic i_w_clk;
    logic i_rst_n;
    int   n_checks;
    int   n_errors;

    fifo_wr_ctrl_if #(.ADDR_WIDTH(4)) bus ();

    fifo_wr_ctrl #(
        .ADDR_WIDTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .i_w_clk (i_w_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    // Free-running write clock.
    initial begin
        i_w_clk = 1'b0;
        forever #5 i_w_clk = ~i_w_clk;
    end

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_w_clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag, input logic exp_wr_en);
        check_val({tag, "_addr"},  32'(bus.o_wr_addr),    32'd0);
        check_val({tag, "_gray"},  32'(bus.o_w_ptr_gray), 32'd0);
        check_val({tag, "_level"}, 32'(bus.o_w_level),    32'd0);
        check_val({tag, "_full"},  32'(bus.o_w_full),     32'd0);
        check_val({tag, "_ovf"},   32'(bus.o_ovf),        32'd0);
        check_val({tag, "_wren"},  32'(bus.o_wr_en),      32'(exp_wr_en));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        i_rst_n            = 1'b0;
        bus.i_w_inc        = 1'b0;
        bus.i_r_ptr_gray   = 5'd0;
        bus.i_afull_thresh = 5'd0;
        bus.i_ovf_clr      = 1'b0;
        #1;
        // Reset state, threshold 0 forces almost-full.
        check_reset_outputs("init", 1'b0);
        check_val("init_afull_t0", 32'(bus.o_w_afull), 32'd1);
        bus.i_afull_thresh = 5'd14;
        #1;
        check_val("init_afull_t14", 32'(bus.o_w_afull), 32'd0);
        #10;
        i_rst_n = 1'b1;
        bus.i_w_inc = 1'b1;
        #1;
        check_val("post_rst_wren", 32'(bus.o_wr_en), 32'd1);

        // Fill: 16 writes with read pointer at 0.
        for (int i = 1; i <= 16; i++) begin
            tick();
            check_val("fill_level", 32'(bus.o_w_level), 32'(i));
            if (i == 13) check_val("afull_at13", 32'(bus.o_w_afull), 32'd0);
            if (i == 14) check_val("afull_at14", 32'(bus.o_w_afull), 32'd1);
            if (i < 16)  check_val("fill_notfull", 32'(bus.o_w_full), 32'd0);
        end
        check_val("fill_full",  32'(bus.o_w_full),     32'd1);
        check_val("fill_gray",  32'(bus.o_w_ptr_gray), 32'h18);
        check_val("fill_addr",  32'(bus.o_wr_addr),    32'd0);
        check_val("fill_wren",  32'(bus.o_wr_en),      32'd0);
        check_val("fill_ovf",   32'(bus.o_ovf),        32'd0);

        // Threshold boundaries at level 16.
        bus.i_afull_thresh = 5'd17;
        #1;
        check_val("afull_t17", 32'(bus.o_w_afull), 32'd0);
        bus.i_afull_thresh = 5'd16;
        #1;
        check_val("afull_t16", 32'(bus.o_w_afull), 32'd1);
        bus.i_afull_thresh = 5'd14;

        // Overflow: write while full.
        tick();
        check_val("ovf_set",    32'(bus.o_ovf),        32'd1);
        check_val("ovf_gray",   32'(bus.o_w_ptr_gray), 32'h18);
        check_val("ovf_addr",   32'(bus.o_wr_addr),    32'd0);
        check_val("ovf_level",  32'(bus.o_w_level),    32'd16);
        bus.i_w_inc   = 1'b0;
        bus.i_ovf_clr = 1'b1;
        tick();
        check_val("ovf_clr", 32'(bus.o_ovf), 32'd0);
        bus.i_w_inc = 1'b1;
        tick();
        check_val("ovf_set_wins", 32'(bus.o_ovf), 32'd1);
        bus.i_w_inc   = 1'b0;
        bus.i_ovf_clr = 1'b0;

        // Drain: read pointer jumps to 4, visible only after 2 edges.
        bus.i_r_ptr_gray = 5'b00110;
        #1;
        check_val("drain_e0_full", 32'(bus.o_w_full), 32'd1);
        tick();
        check_val("drain_e1_full",  32'(bus.o_w_full),  32'd1);
        check_val("drain_e1_level", 32'(bus.o_w_level), 32'd16);
        tick();
        check_val("drain_e2_full",  32'(bus.o_w_full),  32'd0);
        check_val("drain_e2_level", 32'(bus.o_w_level), 32'd12);
        check_val("drain_e2_afull", 32'(bus.o_w_afull), 32'd0);

        // Reset mid-burst, asserted between edges.
        bus.i_w_inc = 1'b1;
        tick();
        tick();
        check_val("burst_level", 32'(bus.o_w_level), 32'd14);
        #3;
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst", 1'b0);
        check_val("midrst_afull", 32'(bus.o_w_afull), 32'd0);
        bus.i_r_ptr_gray = 5'd0;
        #1;
        i_rst_n = 1'b1;
        #1;
        check_val("rel_wren", 32'(bus.o_wr_en),   32'd1);
        check_val("rel_addr", 32'(bus.o_wr_addr), 32'd0);

        // Wrap: 40 writes, read pointer driven 2 entries behind.
        for (int n = 1; n <= 40; n++) begin
            logic [4:0] nb;
            logic [4:0] rb;
            tick();
            nb = 5'(n);
            check_val("wrap_addr",  32'(bus.o_wr_addr),    32'(n % 16));
            check_val("wrap_gray",  32'(bus.o_w_ptr_gray), 32'(to_gray(nb)));
            check_val("wrap_full",  32'(bus.o_w_full),     32'd0);
            check_val("wrap_ovf",   32'(bus.o_ovf),        32'd0);
            check_val("wrap_level", 32'(bus.o_w_level),    32'((n < 4) ? n : 4));
            if (n == 15) check_val("wrap_addr15", 32'(bus.o_wr_addr),    32'd15);
            if (n == 16) check_val("wrap_addr0",  32'(bus.o_wr_addr),    32'd0);
            if (n == 31) check_val("wrap_g10000", 32'(bus.o_w_ptr_gray), 32'h10);
            if (n == 32) check_val("wrap_g00000", 32'(bus.o_w_ptr_gray), 32'h00);
            rb = (n >= 2) ? 5'(n - 2) : 5'd0;
            bus.i_r_ptr_gray = to_gray(rb);
        end
        bus.i_w_inc = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5, meaning memory address width (depth = 2^ADDR_WIDTH), legal values 2..10.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning read-pointer synchronizer depth, legal values 2..4.
REQ-003 The block SHALL have port i_w_clk, input, 1 bit: write-domain clock.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port i_w_inc, input, 1 bit: write request.
REQ-006 The block SHALL have port i_r_ptr_gray, input, ADDR_WIDTH+1 bits: Gray read pointer from the read domain, asynchronous to i_w_clk.
REQ-007 The block SHALL have port i_afull_thresh, input, ADDR_WIDTH+1 bits: almost-full level threshold, quasi-static.
REQ-008 The block SHALL have port i_ovf_clr, input, 1 bit: clears the sticky overflow flag.
REQ-009 The block SHALL have port o_wr_en, output, 1 bit: memory write strobe.
REQ-010 The block SHALL have port o_wr_addr, output, ADDR_WIDTH bits: memory write address.
REQ-011 The block SHALL have port o_w_ptr_gray, output, ADDR_WIDTH+1 bits: registered Gray write pointer to the read domain.
REQ-012 The block SHALL have port o_w_full, output, 1 bit: FIFO full.
REQ-013 The block SHALL have port o_w_afull, output, 1 bit: level >= i_afull_thresh.
REQ-014 The block SHALL have port o_w_level, output, ADDR_WIDTH+1 bits: write-side fill level.
REQ-015 The block SHALL have port o_ovf, output, 1 bit: sticky overflow flag.

Function
REQ-016 The block SHALL hold a binary write pointer wbin and a Gray write pointer, both ADDR_WIDTH+1 bits, updated on the same edge; o_w_ptr_gray SHALL equal (wbin>>1)^wbin, taken directly from a flop with no combinational path to the output.
REQ-017 o_wr_en SHALL equal i_w_inc & ~o_w_full, combinationally; on a rising i_w_clk edge with o_wr_en=1, wbin SHALL increment by 1 modulo 2^(ADDR_WIDTH+1).
REQ-018 o_wr_addr SHALL equal wbin[ADDR_WIDTH-1:0]; it wraps from 2^ADDR_WIDTH-1 to 0.
REQ-019 i_r_ptr_gray SHALL pass through a SYNC_STAGES-deep flop chain (rq_sync); no logic SHALL be placed between the chain stages.
REQ-020 o_w_full SHALL be 1 iff o_w_ptr_gray == {~rq_sync[MSB:MSB-1], rq_sync[MSB-2:0]}; it is combinational from registers only, so a write accepted on edge k blocks the next write from edge k onward.
REQ-021 A read-pointer change stable at edge k SHALL appear in o_w_full, o_w_level and o_w_afull after edge k+SYNC_STAGES-1.
REQ-022 rbin SHALL be the Gray-to-binary conversion of rq_sync; o_w_level SHALL equal (wbin - rbin) mod 2^(ADDR_WIDTH+1), range 0..2^ADDR_WIDTH.
REQ-023 o_w_afull SHALL equal (o_w_level >= i_afull_thresh); a threshold of 0 forces o_w_afull to 1, and a threshold above 2^ADDR_WIDTH forces it to 0.
REQ-024 o_ovf SHALL set on an edge where i_w_inc=1 and o_w_full=1, and SHALL clear on an edge where i_ovf_clr=1; when both occur on the same edge, set wins.
REQ-025 A write attempted while full SHALL NOT change wbin, the Gray pointer or o_wr_addr.
REQ-026 Write and read-pointer movement on the same cycle SHALL both take effect; level reflects both once the read-pointer change is synchronized.

Reset
REQ-027 When i_rst_n=0, wbin, the Gray pointer, all synchronizer stages and o_ovf SHALL go to 0 immediately, without waiting for a clock edge.
REQ-028 After reset, the outputs SHALL be: o_wr_addr=0, o_w_ptr_gray=0, o_w_level=0, o_w_full=0, o_ovf=0; o_w_afull=(i_afull_thresh==0); o_wr_en=i_w_inc.
REQ-029 Reset asserted mid-operation SHALL discard all state; no write strobe SHALL be produced while i_rst_n=0.

Verification
REQ-030 The bench SHALL cover the following scenarios, each with ADDR_WIDTH=4 and SYNC_STAGES=2:
- Reset: assert i_rst_n=0 mid-burst -> all outputs per REQ-028 immediately, without a clock edge.
- Fill: i_r_ptr_gray=0, 16 consecutive writes -> after 16th edge o_w_full=1, o_w_level=16, o_w_ptr_gray=5'b11000, o_wr_addr=0.
- Overflow: while full, drive i_w_inc=1 -> o_wr_en=0, pointer unchanged, o_ovf=1 after edge; then i_ovf_clr=1 with i_w_inc=0 -> o_ovf=0; i_ovf_clr=1 with i_w_inc=1 -> o_ovf stays 1.
- Drain: while full, set i_r_ptr_gray=5'b00110 (binary 4) -> o_w_full=0 and o_w_level=12 exactly 2 edges later, not earlier.
- Almost-full: i_afull_thresh=14, rptr 0 -> o_w_afull=0 at level 13, 1 at level 14.
- Wrap: 40 writes with read pointer tracking 2 entries behind -> o_wr_addr wraps 15->0, Gray pointer wraps 5'b10000->5'b00000, o_w_full never asserted, o_ovf=0.
